// File: rtl/compress_block_core_if.sv
// Block handshake bundle for compress_block_core: start/pixels in, coeffs/done out.
// master: block source and coefficient consumer; slave: the transform core.
interface compress_block_core_if;
    logic               start_block;
    logic signed [8:0]  block            [0:7][0:7];
    logic signed [51:0] quantized_coeffs [0:7][0:7];
    logic               block_done;

    modport master (
        output start_block,
        output block,
        input  quantized_coeffs,
        input  block_done
    );

    modport slave (
        input  start_block,
        input  block,
        output quantized_coeffs,
        output block_done
    );
endinterface

// File: rtl/compress_block_core.sv
// 8x8 fixed-point 2-D DCT-II plus JPEG luminance quantization, one block per 18 cycles.
// Ports: clk, rst (sync, active-high), bus (slave: start_block, block in;
//   quantized_coeffs, block_done out). Macro COMPRESS_BLOCK_QUANT_EN enables the
//   quantizer; without it the output is the rounded unquantized coefficient.
module compress_block_core (
    input  logic                 clk,
    input  logic                 rst,
    compress_block_core_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_DONE
    } state_t;

    // 2048*cos(j*pi/16) for j = 0..8; c(k>0) = 1/2 at Q12
    function automatic int cos_base(input int j);
        int b;
        case (j)
            0:       b = 2048;
            1:       b = 2009;
            2:       b = 1892;
            3:       b = 1703;
            4:       b = 1448;
            5:       b = 1138;
            6:       b = 784;
            7:       b = 400;
            default: b = 0;
        endcase
        return b;
    endfunction

    // C[k][n] = round(4096*c(k)*cos((2n+1)k*pi/16)), folded onto one quadrant
    function automatic logic signed [12:0] cos_rom(input int k, input int n);
        int m;
        int j;
        int v;
        bit neg;
        m   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m <= 8) begin
            j = m;
        end else if (m <= 16) begin
            j   = 16 - m;
            neg = 1'b1;
        end else if (m <= 24) begin
            j   = m - 16;
            neg = 1'b1;
        end else begin
            j = 32 - m;
        end
        v = cos_base(j);
        if (k == 0) begin
            v = 1448;
            neg = 1'b0;
        end
        if (neg) begin
            v = -v;
        end
        return 13'(v);
    endfunction

`ifdef COMPRESS_BLOCK_QUANT_EN
    localparam int QTAB [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    localparam logic [57:0] Q_RND = 58'd1 << 43;

    // round(2^20 / q), evaluated only on constants
    function automatic logic [16:0] recip_of(input int q);
        return 17'((1048576 + q / 2) / q);
    endfunction
`else
    localparam logic [40:0] D_RND = 41'd1 << 23;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_cnt;
    logic [2:0]         w_cnt_nxt;
    logic               w_capture;

    logic signed [8:0]  r_x [0:7][0:7];
    logic signed [24:0] r_t [0:7][0:7];
    logic signed [51:0] r_q [0:7][0:7];

    logic signed [12:0] w_c    [0:7][0:7];
    logic signed [24:0] w_trow [0:7];
    logic signed [40:0] w_ycol [0:7];
    logic [7:0]         w_neg;
    logic [40:0]        w_mag  [0:7];
    logic [51:0]        w_res  [0:7];
    logic signed [51:0] w_qrow [0:7];
`ifdef COMPRESS_BLOCK_QUANT_EN
    logic [16:0]        w_recip [0:63];
`endif

    // Constant ROMs
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                w_c[k][n] = cos_rom(k, n);
            end
        end
    end

`ifdef COMPRESS_BLOCK_QUANT_EN
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            w_recip[i] = recip_of(QTAB[i]);
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state; r_cnt indexes the row (ROW) or frequency u (COL)
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_block) begin
                    w_state_nxt = S_ROW;
                    w_cnt_nxt   = 3'd0;
                    w_capture   = 1'b1;
                end
            end
            S_ROW: begin
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = S_COL;
                end
            end
            S_COL: begin
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Row pass: T[i][k] = sum_n X[i][n]*C[k][n] for row i = r_cnt
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_trow[k] = '0;
            for (int n = 0; n < 8; n++) begin
                w_trow[k] = w_trow[k]
                          + 25'(r_x[r_cnt][n]) * 25'(w_c[k][n]);
            end
        end
    end

    // Column pass: Y[u][v] = sum_i C[u][i]*T[i][v] for u = r_cnt
    always_comb begin
        for (int v = 0; v < 8; v++) begin
            w_ycol[v] = '0;
            for (int i = 0; i < 8; i++) begin
                w_ycol[v] = w_ycol[v]
                          + 41'(w_c[r_cnt][i]) * 41'(r_t[i][v]);
            end
        end
    end

    // Sign-magnitude rounding gives round-half-away-from-zero
    always_comb begin
        for (int v = 0; v < 8; v++) begin
            w_neg[v] = w_ycol[v][40];
            w_mag[v] = w_neg[v] ? 41'(-w_ycol[v]) : 41'(w_ycol[v]);
`ifdef COMPRESS_BLOCK_QUANT_EN
            w_res[v] = 52'((58'(w_mag[v])
                     * 58'(w_recip[{r_cnt, 3'(v)}]) + Q_RND) >> 44);
`else
            w_res[v] = 52'((w_mag[v] + D_RND) >> 24);
`endif
            w_qrow[v] = w_neg[v] ? -$signed(w_res[v])
                                 : $signed(w_res[v]);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '{default: '{default: '0}};
            r_t <= '{default: '{default: '0}};
            r_q <= '{default: '{default: '0}};
        end else begin
            if (w_capture) begin
                r_x <= bus.block;
            end
            if (r_state == S_ROW) begin
                for (int k = 0; k < 8; k++) begin
                    r_t[r_cnt][k] <= w_trow[k];
                end
            end
            if (r_state == S_COL) begin
                for (int v = 0; v < 8; v++) begin
                    r_q[r_cnt][v] <= w_qrow[v];
                end
            end
        end
    end

    assign bus.quantized_coeffs = r_q;
    assign bus.block_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_compress_block_core.sv
// Self-checking bench for compress_block_core: a matrix-level DCT/quant model
// plus directed vectors with hand-computed DC values.
module tb_compress_block_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    compress_block_core_if bus ();

    compress_block_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef COMPRESS_BLOCK_QUANT_EN
    localparam longint DC100  = 50;
    localparam longint DCM128 = -64;
`else
    localparam longint DC100  = 800;
    localparam longint DCM128 = -1024;
`endif

    int q_tab [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    int     c_rom  [8][8];
    longint recip  [64];
    int     cap_x  [8][8];
    longint exp_q  [8][8];
    longint pend_q [8][8];
    bit     pending  = 1'b0;
    bit     model_ok = 1'b0;
    int     cap_cyc  = 0;
    int     done_cyc = 0;
    int     cyc      = 0;
    int     n_chk    = 0;
    int     n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    task automatic init_model();
        real pi;
        real s;
        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++) begin
            s = (k == 0) ? 4096.0 / $sqrt(8.0) : 2048.0;
            for (int n = 0; n < 8; n++)
                c_rom[k][n] = rnd(s * $cos((2 * n + 1) * k * pi / 16.0));
        end
        for (int i = 0; i < 64; i++)
            recip[i] = longint'(rnd(1048576.0 / q_tab[i]));
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) exp_q[u][v] = 0;
    endtask

    // Direct 2-D DCT of the captured block, then the output rounding rule
    function automatic longint model_coef(input int u, input int v);
        longint y;
        longint a;
        longint r;
        y = 0;
        for (int i = 0; i < 8; i++)
            for (int n = 0; n < 8; n++)
                y += longint'(c_rom[u][i]) * c_rom[v][n] * cap_x[i][n];
        a = (y < 0) ? -y : y;
`ifdef COMPRESS_BLOCK_QUANT_EN
        r = (a * recip[u * 8 + v] + (longint'(1) << 43)) >>> 44;
`else
        r = (a + (longint'(1) << 23)) >>> 24;
`endif
        return (y < 0) ? -r : r;
    endfunction

    // Compare process: one done check and one matrix check per cycle
    always @(negedge clk) begin : mon
        bit     idle_now;
        bit     exp_done;
        bit     bad;
        int     bu;
        int     bv;
        idle_now = !pending;
        if (model_ok) begin
            exp_done = pending && (cyc == done_cyc);
            check(bus.block_done == exp_done, "block_done",
                  longint'(bus.block_done), longint'(exp_done));
            if (exp_done) exp_q = pend_q;
            if (!pending || exp_done || cyc <= cap_cyc + 8) begin
                bad = 1'b0;
                bu  = 0;
                bv  = 0;
                for (int u = 0; u < 8; u++)
                    for (int v = 0; v < 8; v++)
                        if (!bad && longint'(bus.quantized_coeffs[u][v])
                                    != exp_q[u][v]) begin
                            bad = 1'b1;
                            bu  = u;
                            bv  = v;
                        end
                check(!bad, $sformatf("coeff[%0d][%0d]", bu, bv),
                      longint'(bus.quantized_coeffs[bu][bv]), exp_q[bu][bv]);
            end
            if (exp_done) pending = 1'b0;
        end
        if (rst) begin
            pending  = 1'b0;
            model_ok = 1'b1;
            for (int u = 0; u < 8; u++)
                for (int v = 0; v < 8; v++) exp_q[u][v] = 0;
        end else if (model_ok && idle_now && bus.start_block) begin
            for (int i = 0; i < 8; i++)
                for (int n = 0; n < 8; n++) cap_x[i][n] = int'(bus.block[i][n]);
            for (int u = 0; u < 8; u++)
                for (int v = 0; v < 8; v++) pend_q[u][v] = model_coef(u, v);
            cap_cyc  = cyc;
            done_cyc = cyc + 17;
            pending  = 1'b1;
        end
    end

    task automatic fill_const(input int val);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) bus.block[r][c] = 9'(val);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                bus.block[r][c] = 9'(((r * 37 + c * 59 + r * c * 11) % 512) - 256);
    endtask

    task automatic fill_checker();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                bus.block[r][c] = ((r + c) % 2 == 1) ? 9'sd255 : -9'sd256;
    endtask

    // One-cycle start pulse, then wait (bounded) for done; lat=-1 on timeout
    task automatic go_and_wait(output int lat, output longint dc);
        int s;
        @(posedge clk);
        #1 bus.start_block = 1'b1;
        s = cyc;
        @(posedge clk);
        #1 bus.start_block = 1'b0;
        lat = -1;
        dc  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.block_done) begin
                lat = cyc - s;
                dc  = longint'(bus.quantized_coeffs[0][0]);
                break;
            end
        end
    endtask

    initial begin : main
        int     lat;
        int     s;
        int     ndone;
        int     dcyc;
        int     d1;
        int     d2;
        longint dc;
        longint dc1;
        longint dc2;

        init_model();
        bus.start_block = 1'b0;
        fill_const(0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(bus.block_done == 1'b0, "reset_done",
              longint'(bus.block_done), 0);
        check(bus.quantized_coeffs[0][0] == 0, "reset_dc",
              longint'(bus.quantized_coeffs[0][0]), 0);

        // All-zero block
        go_and_wait(lat, dc);
        check(lat == 17, "zero_latency", lat, 17);
        check(dc == 0, "zero_dc", dc, 0);

        // Constant 100 with ignored starts at +5 and +12; block changes after capture
        fill_const(100);
        @(posedge clk);
        #1 bus.start_block = 1'b1;
        s = cyc;
        @(posedge clk);
        #1 bus.start_block = 1'b0;
        fill_checker();
        ndone = 0;
        dcyc  = -1;
        dc    = 0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (bus.block_done) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = cyc - s;
                    dc   = longint'(bus.quantized_coeffs[0][0]);
                end
            end
            @(posedge clk);
            #1 bus.start_block = (cyc == s + 5) || (cyc == s + 12);
        end
        bus.start_block = 1'b0;
        check(ndone == 1, "ignored_start_count", ndone, 1);
        check(dcyc == 17, "ignored_start_latency", dcyc, 17);
        check(dc == DC100, "const100_dc", dc, DC100);
        #1;
        check(exp_q[0][0] == DC100, "model_dc100", exp_q[0][0], DC100);

        // Constant -128
        fill_const(-128);
        go_and_wait(lat, dc);
        check(lat == 17, "m128_latency", lat, 17);
        check(dc == DCM128, "m128_dc", dc, DCM128);
        #1;
        check(exp_q[0][0] == DCM128, "model_dcm128", exp_q[0][0], DCM128);

        // Non-flat blocks exercise every coefficient through the model
        fill_ramp();
        go_and_wait(lat, dc);
        check(lat == 17, "ramp_latency", lat, 17);
        fill_checker();
        go_and_wait(lat, dc);
        check(lat == 17, "checker_latency", lat, 17);

        // Reset in cycle 9 of a block aborts it
        fill_ramp();
        @(posedge clk);
        #1 bus.start_block = 1'b1;
        s = cyc;
        @(posedge clk);
        #1 bus.start_block = 1'b0;
        while (cyc < s + 9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.block_done) ndone++;
        end
        check(ndone == 0, "abort_no_done", ndone, 0);
        check(bus.quantized_coeffs[0][0] == 0, "abort_dc",
              longint'(bus.quantized_coeffs[0][0]), 0);
        check(bus.quantized_coeffs[2][5] == 0, "abort_c25",
              longint'(bus.quantized_coeffs[2][5]), 0);
        fill_const(100);
        go_and_wait(lat, dc);
        check(lat == 17, "restart_latency", lat, 17);
        check(dc == DC100, "restart_dc", dc, DC100);

        // Back-to-back with start held high
        fill_const(100);
        @(posedge clk);
        #1 bus.start_block = 1'b1;
        s = cyc;
        @(posedge clk);
        #1 fill_const(-128);
        d1  = -1;
        d2  = -1;
        dc1 = 0;
        dc2 = 0;
        for (int k = 0; k < 50 && d2 < 0; k++) begin
            @(negedge clk);
            if (bus.block_done) begin
                if (d1 < 0) begin
                    d1  = cyc;
                    dc1 = longint'(bus.quantized_coeffs[0][0]);
                end else begin
                    d2  = cyc;
                    dc2 = longint'(bus.quantized_coeffs[0][0]);
                end
            end
        end
        @(posedge clk);
        #1 bus.start_block = 1'b0;
        check(d1 - s == 17, "b2b_first_latency", d1 - s, 17);
        check(d2 - d1 == 18, "b2b_spacing", d2 - d1, 18);
        check(dc1 == DC100, "b2b_dc1", dc1, DC100);
        check(dc2 == DCM128, "b2b_dc2", dc2, DCM128);

        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
